inst_prefetch_buffer: RTL and testbench
=======================================

Name: inst_prefetch_buffer

Overview:
- Front end of the fetch stage. Sits between a multi-cycle instruction memory (req/ack handshake) and the IF/ID pipeline register.
- Issues sequential fetches and buffers fetched instructions with their PC in a small FIFO.
- Presents one instruction per cycle to the decode side, with pc and pc+4 for jump/link logic.
- Honours hazard stalls and flushes on taken branch/jump redirects from the branch unit.

Parameters:
DEPTH, 4, FIFO entries (power of two, ≥2)
RESET_PC, 32'h00000000, first fetch address after reset
NOP_INST, 32'h00000013, instruction presented when the buffer is empty (addi x0,x0,0)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
redirect_valid  input  1  taken branch/jump; flush and refetch
redirect_pc  input  32  new fetch address, valid with redirect_valid
stall  input  1  hazard stall from decode; head entry not consumed
mem_req  output  1  fetch request to instruction memory
mem_addr  output  32  fetch address, word aligned
mem_ack  input  1  one-cycle pulse; mem_rdata valid this cycle
mem_rdata  input  32  fetched instruction word
inst_valid  output  1  head entry valid
inst  output  32  head instruction, or NOP_INST when empty
inst_pc  output  32  PC of head instruction
inst_pcPlusFour  output  32  inst_pc + 4, mod 2^32

Behaviour:
- Reset (async) values:
  - mem_req=0, inst_valid=0, inst=NOP_INST, inst_pc=0, inst_pcPlusFour=4.
  - FIFO count=0, fetch_pc=RESET_PC, FSM=IDLE.
- Storage: FIFO of {pc[31:0], inst[31:0]}.
  - Head is registered storage.
  - inst_valid = (count != 0); inst/inst_pc/inst_pcPlusFour are driven from the head entry.
- Pop: occurs on a rising edge when inst_valid && !stall && !redirect_valid.
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE: if (count + 0) < DEPTH and no redirect this cycle, assert mem_req with mem_addr=fetch_pc and go to WAIT next cycle. mem_req is registered and asserted the cycle after the decision. At most one request is outstanding.
  - WAIT: mem_req held high and mem_addr held stable until mem_ack.
    - On mem_ack: push {fetch_pc, mem_rdata}, fetch_pc += 4, mem_req drops, then IDLE.
    - A push never overflows, because the request was issued only with a free slot reserved (count + 1 ≤ DEPTH counting the outstanding request).
  - DISCARD: entered from WAIT on redirect without same-cycle ack. mem_req stays high until mem_ack. That response is dropped (no push), then IDLE.
- Redirect (redirect_valid=1 at an edge):
  - FIFO flushed (count=0) and fetch_pc=redirect_pc & ~3.
  - inst_valid=0 from the next cycle.
  - Redirect wins over pop and over push in the same cycle.
  - Redirect in WAIT with same-cycle mem_ack: data dropped, go to IDLE, new request to redirect_pc.
  - Redirect in DISCARD: fetch_pc updated again, remain in DISCARD.
- Latency:
  - First mem_req at the first rising edge after reset deasserts.
  - A mem_ack in cycle N gives inst_valid in cycle N+1 if the buffer was empty.
  - Best-case sustained throughput is 1 instruction per 2 cycles with single-cycle ack. A single outstanding request is accepted for this block.
- Simultaneous push and pop: count unchanged, head advances, new entry appended.
- Full: no new request issued until a pop frees a slot. Stall with a full buffer holds everything steady.
- fetch_pc and pc+4 wrap modulo 2^32.
- mem_ack outside WAIT/DISCARD is ignored.
- Reset asserted mid-request: mem_req drops immediately. Memory must abandon the request.

Test Plan:
- Reset release, mem_ack 1 cycle after each mem_req, rdata = 0x11,0x22,0x33 → mem_addr 0,4,8; inst_valid rises the cycle after the first ack with inst=0x11, inst_pc=0, inst_pcPlusFour=4.
- stall held high, DEPTH=4, acks continuous → exactly 4 pushes, mem_req stays 0 afterwards, head stays inst_pc=0. Release stall → pops in order 0,4,8,C, fetching resumes at 0x10.
- Redirect to 0x100 while WAIT on 0x8, ack 3 cycles later with 0xDEAD → 0xDEAD never appears on inst; next mem_addr=0x100; first valid inst_pc=0x100.
- Redirect to 0x200 in the same cycle as mem_ack → ack data dropped, FIFO empty, next request mem_addr=0x200, no DISCARD entry.
- Redirect in the same cycle as pop with 3 entries → count=0 next cycle, inst=NOP_INST, inst_valid=0.
- redirect_pc=0xFFFFFFFC → inst_pcPlusFour=0x00000000, next mem_addr=0x00000000. Async reset pulse mid-WAIT → mem_req=0 immediately, next request to RESET_PC.

Source files
------------

// File: rtl/inst_prefetch_buffer_if.sv
// Handshake bundle between the prefetch buffer, instruction memory,
// the branch unit and the decode stage.
interface inst_prefetch_buffer_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pcPlusFour;

  modport slave (
    input  redirect_valid, redirect_pc, stall, mem_ack, mem_rdata,
    output mem_req, mem_addr, inst_valid, inst, inst_pc, inst_pcPlusFour
  );

  modport master (
    output redirect_valid, redirect_pc, stall, mem_ack, mem_rdata,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc, inst_pcPlusFour
  );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// Fetch-stage front end: sequential single-outstanding fetches into a small
// {pc, inst} FIFO, with stall and branch-redirect flush handling.
module inst_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  inst_prefetch_buffer_if.slave bus
);

  localparam int PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  state_e          state_q;
  logic            memReq_q;
  logic [31:0]     reqAddr_q;
  logic [31:0]     fetchPc_q;
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [31:0]     pcMem_q   [DEPTH];
  logic [31:0]     instMem_q [DEPTH];

  logic        push;
  logic        pop;
  logic        headValid;
  logic [31:0] redirPc;

  assign headValid = (count_q != '0);
  assign redirPc   = bus.redirect_pc & 32'hFFFF_FFFC;
  // Redirect overrides both ends of the FIFO in the same cycle.
  assign pop       = headValid && !bus.stall && !bus.redirect_valid;
  assign push      = (state_q == WAIT) && bus.mem_ack && !bus.redirect_valid;

  always_comb begin
    count_d = count_q;
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    if (bus.redirect_valid) begin
      count_d = '0;
      rdPtr_d = '0;
      wrPtr_d = '0;
    end else begin
      count_d = count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
      if (pop)  rdPtr_d = rdPtr_q + PtrW'(1);
      if (push) wrPtr_d = wrPtr_q + PtrW'(1);
    end
  end

  // Entry storage needs no reset: reads are gated by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      pcMem_q[wrPtr_q]   <= fetchPc_q;
      instMem_q[wrPtr_q] <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      memReq_q  <= 1'b0;
      reqAddr_q <= '0;
      fetchPc_q <= RESET_PC;
      count_q   <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
    end else begin
      count_q <= count_d;
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      case (state_q)
        IDLE: begin
          if (bus.redirect_valid) begin
            fetchPc_q <= redirPc;
          end else if (count_q < FullCount) begin
            memReq_q  <= 1'b1;
            reqAddr_q <= fetchPc_q;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (bus.redirect_valid) begin
            fetchPc_q <= redirPc;
            if (bus.mem_ack) begin
              memReq_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              state_q  <= DISCARD;
            end
          end else if (bus.mem_ack) begin
            fetchPc_q <= fetchPc_q + 32'd4;
            memReq_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        DISCARD: begin
          // The in-flight response belongs to the abandoned path.
          if (bus.redirect_valid) fetchPc_q <= redirPc;
          if (bus.mem_ack) begin
            memReq_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          memReq_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req         = memReq_q;
  assign bus.mem_addr        = reqAddr_q;
  assign bus.inst_valid      = headValid;
  assign bus.inst            = headValid ? instMem_q[rdPtr_q] : NOP_INST;
  assign bus.inst_pc         = headValid ? pcMem_q[rdPtr_q] : 32'h0;
  assign bus.inst_pcPlusFour = bus.inst_pc + 32'd4;

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Self-checking bench for inst_prefetch_buffer: directed vector table,
// corner-case sequences and randomized traffic against a queue model.
module tb_inst_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  inst_prefetch_buffer_if bus();

  inst_prefetch_buffer #(
    .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of {pc, inst} plus the single outstanding fetch.
  logic [63:0] mq[$];
  logic [31:0] mFetch;
  logic [31:0] mReqAddr;
  bit          mReq;
  bit          mDrop;

  task automatic modelReset();
    mq.delete();
    mFetch   = RESET_PC;
    mReqAddr = 32'h0;
    mReq     = 1'b0;
    mDrop    = 1'b0;
  endtask

  task automatic modelStep();
    bit outstanding;
    bit startNew;
    outstanding = mReq;
    if (bus.redirect_valid) begin
      mq.delete();
      mFetch = bus.redirect_pc & 32'hFFFF_FFFC;
      if (outstanding) begin
        if (bus.mem_ack) begin
          mReq  = 1'b0;
          mDrop = 1'b0;
        end else begin
          mDrop = 1'b1;
        end
      end
    end else begin
      startNew = !outstanding && (mq.size() < DEPTH);
      if (mq.size() != 0 && !bus.stall) void'(mq.pop_front());
      if (outstanding && bus.mem_ack) begin
        if (!mDrop) begin
          mq.push_back({mReqAddr, bus.mem_rdata});
          mFetch = mFetch + 32'd4;
        end
        mReq  = 1'b0;
        mDrop = 1'b0;
      end
      if (startNew) begin
        mReq     = 1'b1;
        mReqAddr = mFetch;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel(input string tag);
    logic [31:0] headPc;
    checkOutput({tag, ".mem_req"}, 32'(bus.mem_req), 32'(mReq));
    if (mReq) checkOutput({tag, ".mem_addr"}, bus.mem_addr, mReqAddr);
    checkOutput({tag, ".inst_valid"}, 32'(bus.inst_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      headPc = mq[0][63:32];
      checkOutput({tag, ".inst"}, bus.inst, mq[0][31:0]);
      checkOutput({tag, ".inst_pc"}, bus.inst_pc, headPc);
      checkOutput({tag, ".inst_pcPlusFour"}, bus.inst_pcPlusFour, headPc + 32'd4);
    end else begin
      checkOutput({tag, ".inst_nop"}, bus.inst, NOP_INST);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input bit st, input bit rv, input logic [31:0] rpc,
                               input bit ack, input logic [31:0] rdata);
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.mem_ack        = ack;
    bus.mem_rdata      = rdata;
  endtask

  // Memory responder; data may be derived from the address so order is visible.
  task automatic driveMem(input int ackPct, input int spuriousPct, input bit addrData);
    if (bus.mem_req) begin
      bus.mem_ack   = ($urandom_range(0, 99) < ackPct);
      bus.mem_rdata = addrData ? (bus.mem_addr ^ 32'hC0DE_0000) : $urandom;
    end else begin
      bus.mem_ack   = ($urandom_range(0, 99) < spuriousPct);
      bus.mem_rdata = $urandom;
    end
  endtask

  task automatic applyReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit          st;
    bit          rv;
    logic [31:0] rpc;
    bit          ack;
    logic [31:0] rdata;
    bit          eReq;
    logic [31:0] eAddr;
    bit          eValid;
    logic [31:0] eInst;
    logic [31:0] ePc;
    logic [31:0] ePc4;
  } vec_t;

  function automatic vec_t mk(bit st, bit rv, logic [31:0] rpc, bit ack,
                              logic [31:0] rdata, bit eReq, logic [31:0] eAddr,
                              bit eValid, logic [31:0] eInst, logic [31:0] ePc,
                              logic [31:0] ePc4);
    vec_t v;
    v.st = st; v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdata = rdata;
    v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid;
    v.eInst = eInst; v.ePc = ePc; v.ePc4 = ePc4;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    int fillCycles;
    checks = 0;
    errors = 0;
    reset  = 1'b0;

    // Each record: inputs held for one cycle, expected outputs after that edge.
    vecs[0]  = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h0,         0, NOP_INST, 32'h0,         32'h4);
    vecs[1]  = mk(1, 0, 32'h0,         1, 32'h11,   0, 32'h0,         1, 32'h11,   32'h0,         32'h4);
    vecs[2]  = mk(1, 0, 32'h0,         0, 32'h0,    1, 32'h4,         1, 32'h11,   32'h0,         32'h4);
    vecs[3]  = mk(1, 0, 32'h0,         1, 32'h22,   0, 32'h0,         1, 32'h11,   32'h0,         32'h4);
    vecs[4]  = mk(1, 0, 32'h0,         0, 32'h0,    1, 32'h8,         1, 32'h11,   32'h0,         32'h4);
    vecs[5]  = mk(1, 0, 32'h0,         1, 32'h33,   0, 32'h0,         1, 32'h11,   32'h0,         32'h4);
    vecs[6]  = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'hC,         1, 32'h22,   32'h4,         32'h8);
    vecs[7]  = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'hC,         1, 32'h33,   32'h8,         32'hC);
    vecs[8]  = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'hC,         0, NOP_INST, 32'h0,         32'h0);
    vecs[9]  = mk(0, 1, 32'h200,       1, 32'hDEAD, 0, 32'h0,         0, NOP_INST, 32'h0,         32'h0);
    vecs[10] = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h200,       0, NOP_INST, 32'h0,         32'h0);
    vecs[11] = mk(0, 1, 32'h100,       0, 32'h0,    1, 32'h200,       0, NOP_INST, 32'h0,         32'h0);
    vecs[12] = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h200,       0, NOP_INST, 32'h0,         32'h0);
    vecs[13] = mk(0, 0, 32'h0,         1, 32'hDEAD, 0, 32'h0,         0, NOP_INST, 32'h0,         32'h0);
    vecs[14] = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h100,       0, NOP_INST, 32'h0,         32'h0);
    vecs[15] = mk(1, 0, 32'h0,         1, 32'h44,   0, 32'h0,         1, 32'h44,   32'h100,       32'h104);
    vecs[16] = mk(1, 1, 32'hFFFFFFFE,  0, 32'h0,    0, 32'h0,         0, NOP_INST, 32'h0,         32'h0);
    vecs[17] = mk(1, 0, 32'h0,         0, 32'h0,    1, 32'hFFFFFFFC,  0, NOP_INST, 32'h0,         32'h0);
    vecs[18] = mk(1, 0, 32'h0,         1, 32'h55,   0, 32'h0,         1, 32'h55,   32'hFFFFFFFC,  32'h0);
    vecs[19] = mk(1, 0, 32'h0,         0, 32'h0,    1, 32'h0,         1, 32'h55,   32'hFFFFFFFC,  32'h0);

    $display("[TB] reset state");
    applyReset();
    checkOutput("rst.mem_req", 32'(bus.mem_req), 32'h0);
    checkOutput("rst.inst_valid", 32'(bus.inst_valid), 32'h0);
    checkOutput("rst.inst", bus.inst, NOP_INST);
    checkOutput("rst.inst_pc", bus.inst_pc, 32'h0);
    checkOutput("rst.inst_pcPlusFour", bus.inst_pcPlusFour, 32'h4);

    $display("[TB] directed vector table");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].st, vecs[i].rv, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
      stepCycle();
      checkOutput($sformatf("vec%0d.mem_req", i), 32'(bus.mem_req), 32'(vecs[i].eReq));
      if (vecs[i].eReq)
        checkOutput($sformatf("vec%0d.mem_addr", i), bus.mem_addr, vecs[i].eAddr);
      checkOutput($sformatf("vec%0d.inst_valid", i), 32'(bus.inst_valid), 32'(vecs[i].eValid));
      checkOutput($sformatf("vec%0d.inst", i), bus.inst, vecs[i].eInst);
      if (vecs[i].eValid) begin
        checkOutput($sformatf("vec%0d.inst_pc", i), bus.inst_pc, vecs[i].ePc);
        checkOutput($sformatf("vec%0d.inst_pcPlusFour", i), bus.inst_pcPlusFour, vecs[i].ePc4);
      end
    end

    $display("[TB] full buffer under stall");
    applyReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      driveMem(100, 0, 1'b1);
      stepCycle();
      checkModel("full");
    end
    checkOutput("full.mem_req_idle", 32'(bus.mem_req), 32'h0);
    checkOutput("full.head_pc", bus.inst_pc, 32'h0);
    checkOutput("full.head_inst", bus.inst, 32'hC0DE_0000);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d.valid", i), 32'(bus.inst_valid), 32'h1);
      checkOutput($sformatf("drain%0d.pc", i), bus.inst_pc, 32'(4 * i));
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      stepCycle();
      checkModel("drain");
    end
    checkOutput("drain.resume_req", 32'(bus.mem_req), 32'h1);
    checkOutput("drain.resume_addr", bus.mem_addr, 32'h10);

    $display("[TB] redirect together with pop");
    applyReset();
    fillCycles = 0;
    while (mq.size() < 3 && fillCycles < 20) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      driveMem(100, 0, 1'b0);
      stepCycle();
      checkModel("fill3");
      fillCycles++;
    end
    if (mq.size() != 3) begin
      checks++;
      errors++;
      $display("[TB] FAIL fill3.timeout: got %0d entries, expected 3", mq.size());
    end
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
    stepCycle();
    checkOutput("redirPop.inst_valid", 32'(bus.inst_valid), 32'h0);
    checkOutput("redirPop.inst", bus.inst, NOP_INST);
    checkModel("redirPop");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      driveMem(100, 0, 1'b1);
      stepCycle();
      checkModel("afterRedir");
    end

    $display("[TB] async reset during outstanding fetch");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    stepCycle();
    stepCycle();
    checkModel("preReset");
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("asyncRst.mem_req", 32'(bus.mem_req), 32'h0);
    checkOutput("asyncRst.inst_valid", 32'(bus.inst_valid), 32'h0);
    #2;
    reset = 1'b0;
    stepCycle();
    checkOutput("asyncRst.next_req", 32'(bus.mem_req), 32'h1);
    checkOutput("asyncRst.next_addr", bus.mem_addr, RESET_PC);
    checkModel("postReset");

    $display("[TB] randomized traffic");
    applyReset();
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 6,
                    $urandom, 1'b0, 32'h0);
      driveMem(50, 10, 1'b0);
      stepCycle();
      checkModel("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
